// File: rtl/modulation_pkg.sv
// Shared encodings for the symbol modulator: carrier mapping modes and FSM states.
package modulation_pkg;

    typedef enum logic [2:0] {
        MODE_OOK     = 3'b000,
        MODE_CARRIER = 3'b001,
        MODE_BPSK    = 3'b010,
        MODE_ZERO    = 3'b011,
        MODE_QPSK    = 3'b100,
        MODE_RSVD5   = 3'b101,
        MODE_RSVD6   = 3'b110,
        MODE_RSVD7   = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/symbol_mapper.sv
// Combinational symbol-to-sample mapper. Every negation saturates so that the
// most-negative carrier value maps to the most-positive one instead of wrapping.
module symbol_mapper
    import modulation_pkg::*;
#(
    parameter int W = 12
) (
    input  mode_e              mode,
    input  logic [1:0]         sym,
    input  logic signed [W-1:0] sin_in,
    input  logic signed [W-1:0] cos_in,
    output logic signed [W-1:0] y
);

    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
        logic signed [W-1:0] min_v;
        logic signed [W-1:0] res;
        min_v = {1'b1, {(W-1){1'b0}}};
        if (x == min_v) begin
            res = {1'b0, {(W-1){1'b1}}};
        end else begin
            res = -x;
        end
        return res;
    endfunction

    // Select the carrier phase (or silence) for the current mode and symbol.
    always_comb begin
        y = {W{1'b0}};
        case (mode)
            MODE_OOK: begin
                if (sym[0]) begin
                    y = sin_in;
                end else begin
                    y = {W{1'b0}};
                end
            end
            MODE_CARRIER: y = sin_in;
            MODE_BPSK: begin
                if (sym[0]) begin
                    y = sin_in;
                end else begin
                    y = sat_neg(sin_in);
                end
            end
            MODE_ZERO: y = {W{1'b0}};
            MODE_QPSK: begin
                case (sym)
                    2'b00:   y = sat_neg(cos_in);
                    2'b01:   y = sin_in;
                    2'b10:   y = sat_neg(sin_in);
                    2'b11:   y = cos_in;
                    default: y = {W{1'b0}};
                endcase
            end
            default: y = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/symbol_modulator.sv
// Symbol modulator: accepts symbols through a ready/valid handshake, holds each
// one for sym_period+1 carrier samples and emits the mapped, registered sample.
// The boundary sample (counter at zero) is the last sample of the current
// symbol; a symbol accepted there takes effect from the following sample.
module symbol_modulator
    import modulation_pkg::*;
#(
    parameter int W  = 12,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic signed [W-1:0] sin_in,
    input  logic signed [W-1:0] cos_in,
    input  logic [2:0]          mode,
    input  logic [CW-1:0]       sym_period,
    input  logic [1:0]          data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic signed [W-1:0] mod_out,
    output logic                sym_strobe,
    output logic                underrun
);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          sym_q, sym_d;
    mode_e               mode_q, mode_d;
    logic signed [W-1:0] mod_q, mod_d;

    logic                ready_s;
    logic                accept_s;
    logic                underrun_s;
    logic                boundary_s;
    mode_e               map_mode_s;
    logic [1:0]          map_sym_s;
    logic signed [W-1:0] map_y_s;

    // Mapper source: in IDLE a symbol being accepted is used immediately.
    always_comb begin
        map_mode_s = mode_q;
        map_sym_s  = sym_q;
        if (state_q == ST_IDLE) begin
            map_mode_s = mode_e'(mode);
            map_sym_s  = data_in;
        end else begin
            map_mode_s = mode_q;
            map_sym_s  = sym_q;
        end
    end

    symbol_mapper #(.W(W)) u_mapper (
        .mode   (map_mode_s),
        .sym    (map_sym_s),
        .sin_in (sin_in),
        .cos_in (cos_in),
        .y      (map_y_s)
    );

    // Next-state, handshake and sample-update logic; reset masks all pulses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_d      = sym_q;
        mode_d     = mode_q;
        mod_d      = mod_q;
        ready_s    = 1'b0;
        accept_s   = 1'b0;
        underrun_s = 1'b0;
        boundary_s = 1'b0;
        if (reset) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_s = 1'b1;
                    if (data_valid) begin
                        accept_s = 1'b1;
                        sym_d    = data_in;
                        mode_d   = mode_e'(mode);
                        cnt_d    = sym_period;
                        state_d  = ST_RUN;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                    if (sample_en) begin
                        mod_d = data_valid ? map_y_s : {W{1'b0}};
                    end else begin
                        mod_d = mod_q;
                    end
                end
                ST_RUN: begin
                    boundary_s = sample_en && (cnt_q == {CW{1'b0}});
                    ready_s    = boundary_s;
                    if (sample_en) begin
                        mod_d = map_y_s;
                    end else begin
                        mod_d = mod_q;
                    end
                    if (boundary_s) begin
                        if (data_valid) begin
                            accept_s = 1'b1;
                            sym_d    = data_in;
                            mode_d   = mode_e'(mode);
                            cnt_d    = sym_period;
                        end else begin
                            underrun_s = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else if (sample_en) begin
                        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            sym_q   <= 2'b00;
            mode_q  <= MODE_OOK;
            mod_q   <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            mode_q  <= mode_d;
            mod_q   <= mod_d;
        end
    end

    assign data_ready = ready_s;
    assign sym_strobe = accept_s;
    assign underrun   = underrun_s;
    assign mod_out    = mod_q;

endmodule

// File: doc/symbol_modulator.md
SYMBOL_MODULATOR -- requirements
Module: symbol_modulator

Interface
REQ-001 SHALL have parameter W, default 12: signed two's-complement sample width.
REQ-002 SHALL have parameter CW, default 16: symbol-period counter width.
REQ-003 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port sample_en  input  1: one-cycle strobe, new carrier sample present.
REQ-006 SHALL have port sin_in  input  W: carrier sine sample.
REQ-007 SHALL have port cos_in  input  W: carrier cosine sample.
REQ-008 SHALL have port mode  input  3: 000 OOK, 001 carrier, 010 BPSK, 011 unmodulated-zero, 100 QPSK, 101-111 reserved.
REQ-009 SHALL have port sym_period  input  CW: samples per symbol minus one.
REQ-010 SHALL have port data_in  input  2: symbol bits; OOK/BPSK use bit 0 only.
REQ-011 SHALL have port data_valid  input  1: data_in valid.
REQ-012 SHALL have port data_ready  output  1: block accepts data_in this cycle.
REQ-013 SHALL have port mod_out  output  W: registered modulated sample.
REQ-014 SHALL have port sym_strobe  output  1: one-cycle pulse per accepted symbol.
REQ-015 SHALL have port underrun  output  1: one-cycle pulse at a symbol boundary with no data.

Function
REQ-016 SHALL implement FSM with states IDLE and RUN.
REQ-017 IDLE: data_ready=1; on data_valid, latch data_in, mode, sym_period; load counter with sym_period; go RUN.
REQ-018 RUN: counter decrements on each sample_en; boundary = sample_en && counter==0.
REQ-019 RUN: data_ready=1 only in boundary cycle; accept there reloads symbol, mode, period, counter; stays RUN.
REQ-020 Boundary without data_valid: underrun=1 for that cycle; go IDLE.
REQ-021 Handshake: transfer iff data_valid && data_ready; data_in/data_valid may change freely otherwise.
REQ-022 sym_strobe=1 in every accept cycle, same cycle as transfer.
REQ-023 mod_out updates only on sample_en, one-cycle latency; held otherwise.
REQ-024 RUN mapping (latched symbol s): OOK s0?sin:0; carrier sin; BPSK s0?sin:-sin; zero 0; QPSK 00 -cos, 01 sin, 10 -sin, 11 cos; reserved 0.
REQ-025 Negation SHALL saturate: -(most-negative) yields most-positive; no wrap.
REQ-026 sample_en in IDLE SHALL drive mod_out=0.
REQ-027 sym_period=0: one sample per symbol; every sample_en in RUN is a boundary.
REQ-028 Changes to mode/sym_period mid-symbol SHALL have no effect until next accept.
REQ-029 Accept in IDLE coincident with sample_en: that sample uses newly latched symbol; counter not decremented.

Reset
REQ-030 reset SHALL force state IDLE, counter 0, latched symbol 00, mode 000, mod_out 0, sym_strobe 0, underrun 0.
REQ-031 reset SHALL take priority over all inputs; mid-symbol reset discards current symbol, no underrun pulse.

Structure
REQ-032 Mode encodings and FSM state enum SHALL reside in shared package modulation_pkg.
REQ-033 Saturating-negate mapping SHALL be sub-module symbol_mapper (combinational, parameter W).

Verification
REQ-034 W=12, sym_period=3, mode BPSK, symbols 1,0 back-to-back, sin_in=100 -> mod_out 100 for 4 samples then -100 for 4; sym_strobe twice.
REQ-035 QPSK, sym_period=0, symbols 00,01,10,11, sin=200, cos=300 -> mod_out -300,200,-200,300.
REQ-036 BPSK symbol 0, sin_in=-2048 -> mod_out=2047.
REQ-037 Period 2, no second symbol -> underrun pulse at 3rd sample_en, IDLE, next mod_out 0.
REQ-038 Reset asserted mid-symbol -> next cycle all outputs 0, data_ready=1, no underrun.
REQ-039 Change mode OOK->BPSK mid-symbol -> mapping unchanged until next sym_strobe.
